// File: rtl/i8088_bus_pkg.sv
// Shared encodings for the 8088 bus responder: CPU status codes, T-state FSM and cycle types.
package i8088_bus_pkg;

   localparam logic [2:0] ST_INTA    = 3'b000;
   localparam logic [2:0] ST_IORD    = 3'b001;
   localparam logic [2:0] ST_IOWR    = 3'b010;
   localparam logic [2:0] ST_HALT    = 3'b011;
   localparam logic [2:0] ST_CODE    = 3'b100;
   localparam logic [2:0] ST_MEMRD   = 3'b101;
   localparam logic [2:0] ST_MEMWR   = 3'b110;
   localparam logic [2:0] ST_PASSIVE = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5
   } bus_state_t;

   // Values match the status encoding so a latched status casts straight in.
   typedef enum logic [2:0] {
      CYC_INTA    = 3'b000,
      CYC_IORD    = 3'b001,
      CYC_IOWR    = 3'b010,
      CYC_HALT    = 3'b011,
      CYC_CODE    = 3'b100,
      CYC_MEMRD   = 3'b101,
      CYC_MEMWR   = 3'b110,
      CYC_PASSIVE = 3'b111
   } bus_cyc_t;

   function automatic logic cyc_is_read(input bus_cyc_t c);
      return (c == CYC_INTA) || (c == CYC_IORD) || (c == CYC_CODE) || (c == CYC_MEMRD);
   endfunction

endpackage

// File: rtl/i8088_bus_wait_ctr.sv
// Wait-state down counter (load, saturating decrement) plus the TW watchdog counter
// that only exists when BUS_TIMEOUT_EN is defined.
module i8088_bus_wait_ctr #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   input  logic       tw_clr,
   input  logic       tw_run,
   output logic       zero,
   output logic       last,
   output logic       tmo_hit
);

   if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_tmo_range
      $error("TIMEOUT must be in 1..255");
   end

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)                   cnt <= 8'd0;
      else if (load)             cnt <= load_val;
      else if (dec && cnt != 0)  cnt <= cnt - 8'd1;
   end

   assign zero = (cnt == 8'd0);
   // In TW the cycle may finish on the edge that takes the count to zero.
   assign last = (cnt <= 8'd1);

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] tw_cnt;

   always_ff @(posedge clk) begin
      if (rst || tw_clr)                     tw_cnt <= 8'd0;
      else if (tw_run && tw_cnt != TMO_LAST) tw_cnt <= tw_cnt + 8'd1;
   end

   assign tmo_hit = tw_run && (tw_cnt == TMO_LAST);
`else
   logic unused_tw;
   assign unused_tw = tw_clr ^ tw_run;
   assign tmo_hit   = 1'b0;
`endif

endmodule

// File: rtl/i8088_bus_responder.sv
// 8088 local-bus responder: decodes S2..S0 into T-states, strobes and READY, and forwards
// each cycle to a req/ack backend. Define BUS_TIMEOUT_EN for the TW watchdog.
module i8088_bus_responder
   import i8088_bus_pkg::*;
#(
   parameter int unsigned MEM_WAIT  = 0,
   parameter int unsigned IO_WAIT   = 1,
   parameter int unsigned INTA_WAIT = 1,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  s2_s0,
   input  logic [19:0] ad_in,
   input  logic [7:0]  cpu_dout,
   input  logic        lock_n,
   output logic        ready,
   output logic [7:0]  din,
   output logic        ale,
   output logic        memr_n,
   output logic        memw_n,
   output logic        ior_n,
   output logic        iow_n,
   output logic        inta_n,
   output logic        halt,
   output logic        req,
   output logic        req_we,
   output logic        req_io,
   output logic        req_inta,
   output logic        req_lock,
   output logic [19:0] req_addr,
   output logic [7:0]  req_wdata,
   input  logic        ack,
   input  logic [7:0]  ack_rdata,
   output logic        timeout
);

   if (MEM_WAIT > 255 || IO_WAIT > 255 || INTA_WAIT > 255) begin : g_wait_range
      $error("wait-state parameters must fit in 8 bits");
   end

   localparam logic [7:0] MEM_W  = 8'(MEM_WAIT);
   localparam logic [7:0] IO_W   = 8'(IO_WAIT);
   localparam logic [7:0] INTA_W = 8'(INTA_WAIT);

   bus_state_t state;
   bus_cyc_t   cyc;
   logic [2:0] prev_st;
   logic       pending;
   logic       start, ack_ok, tmo_fire;
   logic [7:0] wait_load;
   logic       wait_zero, wait_last, tmo_hit;

   assign start  = (state == S_IDLE) && (prev_st == ST_PASSIVE) && (s2_s0 != ST_PASSIVE);
   // pending is only ever set between T2 and TW, so this alone bounds the ack window.
   assign ack_ok = pending && ack;

   always_comb begin
      wait_load = 8'd0;
      case (s2_s0)
         ST_INTA:                      wait_load = INTA_W;
         ST_IORD, ST_IOWR:             wait_load = IO_W;
         ST_CODE, ST_MEMRD, ST_MEMWR:  wait_load = MEM_W;
         default:                      wait_load = 8'd0;
      endcase
   end

   i8088_bus_wait_ctr #(.TIMEOUT(TIMEOUT)) u_wait (
      .clk      (CLK),
      .rst      (RESET),
      .load     (start),
      .load_val (wait_load),
      .dec      (state == S_TW),
      .tw_clr   (state == S_T3),
      .tw_run   (state == S_TW),
      .zero     (wait_zero),
      .last     (wait_last),
      .tmo_hit  (tmo_hit)
   );

   assign tmo_fire = tmo_hit && pending && !ack;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         cyc       <= CYC_PASSIVE;
         prev_st   <= ST_PASSIVE;
         pending   <= 1'b0;
         ready     <= 1'b1;
         din       <= 8'hFF;
         ale       <= 1'b0;
         {memr_n, memw_n, ior_n, iow_n, inta_n} <= 5'b11111;
         halt      <= 1'b0;
         req       <= 1'b0;
         req_we    <= 1'b0;
         req_io    <= 1'b0;
         req_inta  <= 1'b0;
         req_lock  <= 1'b0;
         req_addr  <= 20'd0;
         req_wdata <= 8'd0;
      end else begin
         prev_st <= s2_s0;
         ale     <= 1'b0;
         req     <= 1'b0;
         halt    <= 1'b0;

         if (ack_ok) begin
            pending <= 1'b0;
            if (cyc_is_read(cyc)) din <= ack_rdata;
         end

         case (state)
            S_IDLE: if (start) begin
               state    <= S_T1;
               ale      <= 1'b1;
               req_addr <= ad_in;
               cyc      <= bus_cyc_t'(s2_s0);
            end
            S_T1: begin
               if (cyc == CYC_HALT) begin
                  halt  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  state    <= S_T2;
                  req      <= 1'b1;
                  pending  <= 1'b1;
                  req_we   <= (cyc == CYC_IOWR) || (cyc == CYC_MEMWR);
                  req_io   <= (cyc == CYC_IORD) || (cyc == CYC_IOWR);
                  req_inta <= (cyc == CYC_INTA);
                  req_lock <= !lock_n;
                  if ((cyc == CYC_IOWR) || (cyc == CYC_MEMWR)) req_wdata <= cpu_dout;
                  case (cyc)
                     CYC_CODE, CYC_MEMRD: memr_n <= 1'b0;
                     CYC_MEMWR:           memw_n <= 1'b0;
                     CYC_IORD:            ior_n  <= 1'b0;
                     CYC_IOWR:            iow_n  <= 1'b0;
                     default:             inta_n <= 1'b0;
                  endcase
               end
            end
            S_T2: state <= S_T3;
            S_T3: begin
               if (!pending && wait_zero) begin
                  state <= S_T4;
                  ready <= 1'b1;
                  {memr_n, memw_n, ior_n, iow_n, inta_n} <= 5'b11111;
               end else begin
                  state <= S_TW;
                  ready <= 1'b0;
               end
            end
            S_TW: begin
               if (!pending && wait_last) begin
                  state <= S_T4;
                  ready <= 1'b1;
                  {memr_n, memw_n, ior_n, iow_n, inta_n} <= 5'b11111;
               end else if (tmo_fire) begin
                  state   <= S_T4;
                  ready   <= 1'b1;
                  pending <= 1'b0;
                  {memr_n, memw_n, ior_n, iow_n, inta_n} <= 5'b11111;
                  if (cyc_is_read(cyc)) din <= 8'hFF;
               end
            end
            S_T4:    state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BUS_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RESET)         timeout <= 1'b0;
      else if (tmo_fire) timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i8088_bus_responder.sv
// Directed bench for i8088_bus_responder; the watchdog-timeout step runs when BUS_TIMEOUT_EN is defined.
module tb_i8088_bus_responder;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [2:0]  s2_s0;
   logic [19:0] ad_in;
   logic [7:0]  cpu_dout;
   logic        lock_n;
   logic        ready;
   logic [7:0]  din;
   logic        ale, memr_n, memw_n, ior_n, iow_n, inta_n, halt;
   logic        req, req_we, req_io, req_inta, req_lock;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;
   logic        ack;
   logic [7:0]  ack_rdata;
   logic        timeout;
   logic [4:0]  strb;

   int checks = 0;
   int errors = 0;
   int nreq, nlow;

   i8088_bus_responder #(.MEM_WAIT(0), .IO_WAIT(1), .INTA_WAIT(1), .TIMEOUT(4)) dut (
      .CLK(CLK), .RESET(RESET), .s2_s0(s2_s0), .ad_in(ad_in), .cpu_dout(cpu_dout),
      .lock_n(lock_n), .ready(ready), .din(din), .ale(ale), .memr_n(memr_n),
      .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n), .inta_n(inta_n), .halt(halt),
      .req(req), .req_we(req_we), .req_io(req_io), .req_inta(req_inta),
      .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
      .ack_rdata(ack_rdata), .timeout(timeout)
   );

   always #5 CLK = ~CLK;
   assign strb = {memr_n, memw_n, ior_n, iow_n, inta_n};

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_strb"},  strb, 5'h1F);
      chk({tag, "_ready"}, ready, 1);
      chk({tag, "_ale"},   ale, 0);
      chk({tag, "_req"},   req, 0);
      chk({tag, "_halt"},  halt, 0);
      chk({tag, "_tmo"},   timeout, 0);
      chk({tag, "_din"},   din, 8'hFF);
      chk({tag, "_addr"},  req_addr, 0);
      chk({tag, "_wdata"}, req_wdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench timeout");
   end

   initial begin
      RESET = 1'b1; s2_s0 = 3'b111; ad_in = '0; cpu_dout = '0; lock_n = 1'b1;
      ack = 1'b0; ack_rdata = '0;
      tick(); tick();
      chk_reset("rst");
      RESET = 1'b0;
      tick();

      // mem read, zero-latency ack
      s2_s0 = 3'b101; ad_in = 20'h12345; lock_n = 1'b0;
      tick();
      chk("mr_ale", ale, 1); chk("mr_addr", req_addr, 20'h12345);
      chk("mr_t1_strb", strb, 5'h1F); chk("mr_t1_req", req, 0);
      tick();
      chk("mr_req", req, 1); chk("mr_t2_strb", strb, 5'b01111);
      chk("mr_we", req_we, 0); chk("mr_io", req_io, 0); chk("mr_lock", req_lock, 1);
      chk("mr_t2_ready", ready, 1);
      ack = 1'b1; ack_rdata = 8'h5A;
      tick();
      ack = 1'b0;
      chk("mr_t3_strb", strb, 5'b01111); chk("mr_t3_ready", ready, 1);
      chk("mr_din", din, 8'h5A); chk("mr_req_pulse", req, 0);
      s2_s0 = 3'b111; lock_n = 1'b1;
      tick();
      chk("mr_t4_strb", strb, 5'h1F); chk("mr_t4_ready", ready, 1);
      tick();
      chk("mr_idle_ready", ready, 1);

      // IO write, ack three cycles after req
      s2_s0 = 3'b010; ad_in = 20'h003F8; cpu_dout = 8'hC3;
      tick();
      chk("iow_ale", ale, 1);
      tick();
      chk("iow_req", req, 1); chk("iow_io", req_io, 1); chk("iow_we", req_we, 1);
      chk("iow_wdata", req_wdata, 8'hC3); chk("iow_strb", strb, 5'b11101);
      chk("iow_addr", req_addr, 20'h003F8);
      cpu_dout = 8'h00; s2_s0 = 3'b111;
      nlow = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ready === 1'b0) nlow++;
         if (i == 3) chk("iow_tw_strb", strb, 5'b11101);
         ack = (i == 2);
      end
      chk("iow_ready_low", nlow, 3);
      chk("iow_end_strb", strb, 5'h1F); chk("iow_wdata_hold", req_wdata, 8'hC3);

      // halt
      s2_s0 = 3'b011;
      tick();
      chk("hlt_ale", ale, 1); chk("hlt_t1_req", req, 0);
      tick();
      chk("hlt_pulse", halt, 1); chk("hlt_req", req, 0); chk("hlt_strb", strb, 5'h1F);
      tick();
      chk("hlt_off", halt, 0); chk("hlt_strb2", strb, 5'h1F);
      s2_s0 = 3'b111;
      tick();

      // stale active status must not retrigger
      s2_s0 = 3'b101; ad_in = 20'hF0000;
      nreq = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (req === 1'b1) nreq++;
         ack = (i == 1); ack_rdata = 8'h77;
      end
      chk("hold_one_req", nreq, 1); chk("hold_din", din, 8'h77);
      s2_s0 = 3'b111;
      tick();
      s2_s0 = 3'b101;
      tick();
      chk("retrig_ale", ale, 1);
      tick();
      chk("retrig_req", req, 1);
      ack = 1'b1; ack_rdata = 8'h99;
      tick();
      ack = 1'b0; s2_s0 = 3'b111;
      tick(); tick();
      chk("retrig_din", din, 8'h99);

      // INTA: one wait state with an immediate ack
      s2_s0 = 3'b000;
      tick(); tick();
      chk("inta_req", req_inta, 1); chk("inta_strb", strb, 5'b11110);
      ack = 1'b1; ack_rdata = 8'h08; s2_s0 = 3'b111;
      tick();
      ack = 1'b0;
      chk("inta_t3_ready", ready, 1);
      tick();
      chk("inta_tw_ready", ready, 0);
      tick();
      chk("inta_t4_ready", ready, 1); chk("inta_din", din, 8'h08);
      chk("inta_t4_strb", strb, 5'h1F);
      tick();

`ifdef BUS_TIMEOUT_EN
      // IO read never acked: watchdog completes after 4 TW cycles
      s2_s0 = 3'b001;
      tick(); tick();
      chk("tmo_strb", strb, 5'b11011);
      s2_s0 = 3'b111;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tmo_wait", ready, 0);
      end
      tick();
      chk("tmo_ready", ready, 1); chk("tmo_din", din, 8'hFF);
      chk("tmo_flag", timeout, 1); chk("tmo_strb_end", strb, 5'h1F);
      tick(); tick();
      chk("tmo_sticky", timeout, 1);
`else
      // IO read acked late: TW holds for as long as it takes
      s2_s0 = 3'b001;
      tick(); tick();
      chk("ior_strb", strb, 5'b11011);
      s2_s0 = 3'b111;
      tick();
      for (int i = 0; i < 8; i++) tick();
      chk("ior_long_wait", ready, 0); chk("ior_tmo", timeout, 0);
      ack = 1'b1; ack_rdata = 8'h3C;
      tick();
      ack = 1'b0;
      chk("ior_after_ack", ready, 0);
      tick();
      chk("ior_ready", ready, 1); chk("ior_din", din, 8'h3C);
      tick();
`endif

      // RESET during TW of a mem read, then a late ack
      s2_s0 = 3'b101; ad_in = 20'hABCDE;
      tick(); tick(); tick(); tick();
      chk("rtw_ready", ready, 0); chk("rtw_strb", strb, 5'b01111);
      RESET = 1'b1; s2_s0 = 3'b111;
      tick();
      chk_reset("rst_mid");
      RESET = 1'b0; ack = 1'b1; ack_rdata = 8'hAA;
      tick();
      ack = 1'b0;
      chk("late_ack_din", din, 8'hFF); chk("late_ack_req", req, 0);
      chk("late_ack_strb", strb, 5'h1F); chk("late_ack_ready", ready, 1);
      tick();
      chk("late_ack_din2", din, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
